// File: rtl/octree_sram_arbiter_if.sv
// Requester-side bus of the Octree SRAM arbiter: per-requester request/address/data
// vectors in, one-hot grant and read-return out.
interface octree_sram_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0]                 we_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]                 lock_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]              rdata_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, lock_i,
    output gnt_o, rvalid_o, rdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, lock_i,
    input  gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/octree_sram_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port SRAM among the host,
// Searcher and Updater; routes 1-cycle-latency read data back to the issuer.
module octree_sram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  octree_sram_arbiter_if.slave          bus,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o,
  output logic                          locked_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic               rtag_vld_p1;
  logic [IDX_W-1:0]   rtag_id_p1;

  logic [NUM_REQ-1:0] others_req;
  logic               burst_full;
  logic               hold;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   win;
  logic               beat;
  logic               found;
  int                 idx;

  // Lock survives only while the owner keeps lock_i high and has not exhausted its
  // burst budget while someone else is waiting.
  always_comb begin
    others_req = bus.req_i;
    others_req[owner_q] = 1'b0;
    burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));
    hold = (state_q == ST_LOCK) && bus.lock_i[owner_q] && !(burst_full && (|others_req));
  end

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (hold) begin
      if (bus.req_i[owner_q]) begin
        gnt[owner_q] = 1'b1;
        win          = owner_q;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!found && bus.req_i[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          win      = IDX_W'(idx);
        end
      end
    end
  end

  assign beat      = |(bus.req_i & gnt);
  assign bus.gnt_o = gnt;

  always_comb begin
    sram_req_o   = beat;
    sram_we_o    = beat & bus.we_i[win];
    sram_addr_o  = beat ? bus.addr_i[win]  : '0;
    sram_wdata_o = beat ? bus.wdata_i[win] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else if (hold) begin
      if (beat && !burst_full) burst_cnt_q <= burst_cnt_q + 1'b1;
    end else if (beat) begin
      owner_q     <= win;
      ptr_q       <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      state_q     <= bus.lock_i[win] ? ST_LOCK : ST_ARB;
      burst_cnt_q <= bus.lock_i[win] ? CNT_W'(1) : '0;
    end else begin
      state_q     <= ST_ARB;
      burst_cnt_q <= '0;
    end
  end

  // Stage p1: read tag, aligned with the SRAM's registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rtag_vld_p1 <= 1'b0;
      rtag_id_p1  <= '0;
    end else begin
      rtag_vld_p1 <= beat & ~bus.we_i[win];
      rtag_id_p1  <= win;
    end
  end

  always_comb begin
    bus.rvalid_o = '0;
    if (rtag_vld_p1) bus.rvalid_o[rtag_id_p1] = 1'b1;
    bus.rdata_o  = rtag_vld_p1 ? sram_rdata_i : '0;
  end

  assign owner_o  = owner_q;
  assign locked_o = (state_q == ST_LOCK);

endmodule
